pipe_mem_stage: RTL and testbench

- Memory-access stage, directly downstream of the execute stage and upstream of write-back.
- Holds one instruction per cycle.
- Collects the data-SRAM response for any load/store the execute stage issued.
- Sign/zero-extends load data, merges timer-read results and forwards everything to write-back.
- Buffers a response that arrives while write-back is stalled, and discards responses that belong to flushed instructions.

---
 rtl/pipe_mem_stage.sv | 199 +++++++++++++++++++
 tb/tb_pipe_mem_stage.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage: memory-access stage between execute and write-back; collects data-SRAM responses.
// Defining PIPE_MEM_FWD_EN adds the fwd_valid/fwd_data same-cycle forwarding outputs.
module pipe_mem_stage #(
    parameter int DATA_W = 32,
    parameter int EXC_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              from_valid,
    input  logic              from_allowin,
    input  logic [DATA_W-1:0] from_pc,
    input  logic [DATA_W-1:0] alu_result_EX,
    input  logic              rf_we_EX,
    input  logic [4:0]        rf_waddr_EX,
    input  logic              res_from_mem_EX,
    input  logic [4:0]        load_op_EX,
    input  logic              mem_req_EX,
    input  logic              rd_cnt_EX,
    input  logic [DATA_W-1:0] rd_timer_EX,
    input  logic [79:0]       csr_bus_EX,
    input  logic              ertn_EX,
    input  logic [EXC_W-1:0]  exc_EX,
    input  logic              ex_WB,
    input  logic              flush_WB,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    output logic              to_valid,
    output logic              to_allowin,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mem_wait,
    output logic [79:0]       csr_bus,
    output logic              ertn_out,
    output logic              ex_MEM,
    output logic              flush_MEM,
    output logic [EXC_W-1:0]  exc_out,
    output logic [DATA_W-1:0] vaddr,
`ifdef PIPE_MEM_FWD_EN
    output logic              fwd_valid,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic [DATA_W-1:0] PC
);

    localparam int CSR_EN_BIT = 65;
    localparam int CSR_WE_BIT = 64;

    logic              r_valid;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_alu_result;
    logic              r_rf_we;
    logic [4:0]        r_rf_waddr;
    logic              r_res_from_mem;
    logic [4:0]        r_load_op;
    logic              r_mem_req;
    logic              r_rd_cnt;
    logic [DATA_W-1:0] r_rd_timer;
    logic [79:0]       r_csr_bus;
    logic              r_ertn;
    logic [EXC_W-1:0]  r_exc;
    logic              r_buf_valid;
    logic [DATA_W-1:0] r_buf_data;
    logic [1:0]        r_discard_cnt;

    logic              w_flush;
    logic              w_discard;
    logic              w_data_ok_live;
    logic              w_ready_go;
    logic              w_allowin;
    logic              w_leave;
    logic              w_cnt_inc;
    logic              w_cnt_dec;
    logic [1:0]        w_addr_lo;
    logic [DATA_W-1:0] w_mem_rdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_result;

    // A response is swallowed while the discard counter still owes flushed requests their data_ok.
    assign w_flush        = ex_WB | flush_WB;
    assign w_discard      = (r_discard_cnt != 2'd0);
    assign w_data_ok_live = data_sram_data_ok & ~w_discard;
    assign w_ready_go     = r_valid & (~r_mem_req | r_buf_valid | w_data_ok_live);
    assign w_allowin      = ~r_valid | (w_ready_go & from_allowin) | w_flush;
    assign w_leave        = w_ready_go & from_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (w_allowin) begin
            r_valid <= from_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc           <= '0;
            r_alu_result   <= '0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= '0;
            r_res_from_mem <= 1'b0;
            r_load_op      <= '0;
            r_mem_req      <= 1'b0;
            r_rd_cnt       <= 1'b0;
            r_rd_timer     <= '0;
            r_csr_bus      <= '0;
            r_ertn         <= 1'b0;
            r_exc          <= '0;
        end else if (from_valid & w_allowin) begin
            r_pc           <= from_pc;
            r_alu_result   <= alu_result_EX;
            r_rf_we        <= rf_we_EX;
            r_rf_waddr     <= rf_waddr_EX;
            r_res_from_mem <= res_from_mem_EX;
            r_load_op      <= load_op_EX;
            r_mem_req      <= mem_req_EX;
            r_rd_cnt       <= rd_cnt_EX;
            r_rd_timer     <= rd_timer_EX;
            r_csr_bus      <= csr_bus_EX;
            r_ertn         <= ertn_EX;
            r_exc          <= exc_EX;
        end
    end

    // Hold a response that arrives while write-back is stalled so the request is never reissued.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_valid <= 1'b0;
            r_buf_data  <= '0;
        end else if (w_flush | w_leave) begin
            r_buf_valid <= 1'b0;
        end else if (w_data_ok_live & r_valid & r_mem_req & ~from_allowin) begin
            r_buf_valid <= 1'b1;
            r_buf_data  <= data_sram_rdata;
        end
    end

    assign w_cnt_inc = w_flush & r_valid & r_mem_req & ~r_buf_valid & ~w_data_ok_live;
    assign w_cnt_dec = data_sram_data_ok & w_discard;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_discard_cnt <= 2'd0;
        end else if (w_cnt_inc & ~w_cnt_dec & (r_discard_cnt != 2'd3)) begin
            r_discard_cnt <= r_discard_cnt + 2'd1;
        end else if (w_cnt_dec & ~w_cnt_inc) begin
            r_discard_cnt <= r_discard_cnt - 2'd1;
        end
    end

    assign w_addr_lo   = r_alu_result[1:0];
    assign w_mem_rdata = r_buf_valid ? r_buf_data : data_sram_rdata;
    assign w_byte      = w_mem_rdata[{w_addr_lo, 3'b000} +: 8];
    assign w_half      = w_addr_lo[1] ? w_mem_rdata[31:16] : w_mem_rdata[15:0];

    // load_op is one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}; anything else returns the full word.
    always_comb begin
        w_load_data = w_mem_rdata;
        if (r_load_op[4]) begin
            w_load_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
        end else if (r_load_op[3]) begin
            w_load_data = {{(DATA_W-8){1'b0}}, w_byte};
        end else if (r_load_op[2]) begin
            w_load_data = {{(DATA_W-16){w_half[15]}}, w_half};
        end else if (r_load_op[1]) begin
            w_load_data = {{(DATA_W-16){1'b0}}, w_half};
        end
    end

    assign w_result = r_res_from_mem ? w_load_data :
                      r_rd_cnt       ? r_rd_timer  : r_alu_result;

    assign to_valid   = w_ready_go & ~w_flush;
    assign to_allowin = w_allowin;
    assign rf_we      = r_valid & r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = w_result;
    assign mem_wait   = r_valid & r_res_from_mem & ~w_ready_go;
    assign csr_bus    = {r_csr_bus[79:CSR_EN_BIT+1],
                         r_csr_bus[CSR_EN_BIT] & r_valid,
                         r_csr_bus[CSR_WE_BIT] & r_valid,
                         r_csr_bus[CSR_WE_BIT-1:0]};
    assign ertn_out   = r_valid & r_ertn;
    assign ex_MEM     = r_valid & (r_exc != '0);
    assign flush_MEM  = r_valid & r_ertn;
    assign exc_out    = r_exc;
    assign vaddr      = r_alu_result;
    assign PC         = r_pc;

`ifdef PIPE_MEM_FWD_EN
    assign fwd_valid = rf_we & w_ready_go;
    assign fwd_data  = w_result;
`else
    // Without the forwarding port, decode stalls on mem_wait and picks the value up from write-back.
`endif

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Self-checking bench for pipe_mem_stage: table of single-instruction vectors, hand-written
// buffer/flush/reset sequences, and randomized traffic against a transaction-level model.
module tb_pipe_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        from_valid;
    logic        from_allowin;
    logic [31:0] from_pc;
    logic [31:0] alu_result_EX;
    logic        rf_we_EX;
    logic [4:0]  rf_waddr_EX;
    logic        res_from_mem_EX;
    logic [4:0]  load_op_EX;
    logic        mem_req_EX;
    logic        rd_cnt_EX;
    logic [31:0] rd_timer_EX;
    logic [79:0] csr_bus_EX;
    logic        ertn_EX;
    logic [5:0]  exc_EX;
    logic        ex_WB;
    logic        flush_WB;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        to_valid;
    logic        to_allowin;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        mem_wait;
    logic [79:0] csr_bus;
    logic        ertn_out;
    logic        ex_MEM;
    logic        flush_MEM;
    logic [5:0]  exc_out;
    logic [31:0] vaddr;
    logic [31:0] PC;
`ifdef PIPE_MEM_FWD_EN
    logic        fwd_valid;
    logic [31:0] fwd_data;
`endif

    int checkCount = 0;
    int failCount  = 0;

    pipe_mem_stage #(.DATA_W(32), .EXC_W(6)) dut (
        .clk(clk), .reset(reset),
        .from_valid(from_valid), .from_allowin(from_allowin), .from_pc(from_pc),
        .alu_result_EX(alu_result_EX), .rf_we_EX(rf_we_EX), .rf_waddr_EX(rf_waddr_EX),
        .res_from_mem_EX(res_from_mem_EX), .load_op_EX(load_op_EX), .mem_req_EX(mem_req_EX),
        .rd_cnt_EX(rd_cnt_EX), .rd_timer_EX(rd_timer_EX), .csr_bus_EX(csr_bus_EX),
        .ertn_EX(ertn_EX), .exc_EX(exc_EX), .ex_WB(ex_WB), .flush_WB(flush_WB),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .to_valid(to_valid), .to_allowin(to_allowin), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .mem_wait(mem_wait), .csr_bus(csr_bus), .ertn_out(ertn_out),
        .ex_MEM(ex_MEM), .flush_MEM(flush_MEM), .exc_out(exc_out), .vaddr(vaddr),
`ifdef PIPE_MEM_FWD_EN
        .fwd_valid(fwd_valid), .fwd_data(fwd_data),
`endif
        .PC(PC)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rfWe;
        logic [4:0]  waddr;
        logic        resMem;
        logic [4:0]  loadOp;
        logic        memReq;
        logic        rdCnt;
        logic [31:0] timer;
        logic [31:0] addr;
        logic [31:0] data;
    } instr_t;

    typedef struct {
        string       name;
        logic [4:0]  loadOp;
        logic        rfWe;
        logic        resMem;
        logic        memReq;
        logic        rdCnt;
        logic        ertn;
        logic [5:0]  exc;
        logic [31:0] addr;
        logic [31:0] timer;
        logic [31:0] rdata;
        logic [31:0] expWdata;
        logic        expExMem;
        logic        expFlush;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic driveIdle();
        from_valid      = 1'b0;
        from_pc         = 32'h0;
        alu_result_EX   = 32'h0;
        rf_we_EX        = 1'b0;
        rf_waddr_EX     = 5'd0;
        res_from_mem_EX = 1'b0;
        load_op_EX      = 5'd0;
        mem_req_EX      = 1'b0;
        rd_cnt_EX       = 1'b0;
        rd_timer_EX     = 32'h0;
        csr_bus_EX      = 80'h0;
        ertn_EX         = 1'b0;
        exc_EX          = 6'd0;
    endtask

    task automatic driveInstr(input instr_t t);
        driveIdle();
        from_valid      = 1'b1;
        from_pc         = t.addr ^ 32'h1C00_0000;
        alu_result_EX   = t.addr;
        rf_we_EX        = t.rfWe;
        rf_waddr_EX     = t.waddr;
        res_from_mem_EX = t.resMem;
        load_op_EX      = t.loadOp;
        mem_req_EX      = t.memReq;
        rd_cnt_EX       = t.rdCnt;
        rd_timer_EX     = t.timer;
    endtask

    function automatic instr_t makeLoad(input logic [4:0] op, input logic [31:0] addr);
        instr_t t;
        t = '{rfWe: 1'b1, waddr: 5'd7, resMem: 1'b1, loadOp: op, memReq: 1'b1,
              rdCnt: 1'b0, timer: 32'h0, addr: addr, data: 32'h0};
        return t;
    endfunction

    function automatic vec_t makeVec(input string name, input logic [4:0] op, input logic rfWe,
                                     input logic resMem, input logic memReq, input logic rdCnt,
                                     input logic ertn, input logic [5:0] exc, input logic [31:0] addr,
                                     input logic [31:0] timer, input logic [31:0] rdata,
                                     input logic [31:0] expWdata, input logic expExMem, input logic expFlush);
        vec_t v;
        v.name = name; v.loadOp = op; v.rfWe = rfWe; v.resMem = resMem; v.memReq = memReq;
        v.rdCnt = rdCnt; v.ertn = ertn; v.exc = exc; v.addr = addr; v.timer = timer;
        v.rdata = rdata; v.expWdata = expWdata; v.expExMem = expExMem; v.expFlush = expFlush;
        return v;
    endfunction

    // Architectural result of an instruction, computed straight from the ISA load rules.
    function automatic logic [31:0] refResult(input instr_t t);
        int unsigned a, b, h, d;
        d = t.data;
        a = t.addr % 4;
        b = (d >> (8 * a)) % 256;
        h = (a >= 2) ? (d / 65536) : (d % 65536);
        if (t.resMem) begin
            if (t.loadOp == 5'b10000) return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
            if (t.loadOp == 5'b01000) return b;
            if (t.loadOp == 5'b00100) return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
            if (t.loadOp == 5'b00010) return h;
            return d;
        end
        if (t.rdCnt) return t.timer;
        return t.addr;
    endfunction

    function automatic instr_t randInstr();
        instr_t t;
        logic [31:0] r;
        int kind;
        r    = $urandom;
        kind = $urandom_range(0, 3);
        t.waddr = r[4:0]; t.addr = $urandom; t.data = $urandom; t.timer = $urandom;
        t.rfWe = 1'b0; t.resMem = 1'b0; t.loadOp = 5'd0; t.memReq = 1'b0; t.rdCnt = 1'b0;
        case (kind)
            0: t.rfWe = 1'b1;
            1: begin t.rfWe = 1'b1; t.rdCnt = 1'b1; end
            2: begin
                t.rfWe = 1'b1; t.resMem = 1'b1; t.memReq = 1'b1;
                t.loadOp = 5'b00001 << $urandom_range(0, 4);
            end
            default: t.memReq = 1'b1;
        endcase
        return t;
    endfunction

    // One instruction enters, its response (if any) arrives the next cycle with write-back ready.
    task automatic applyStimulus(input vec_t v, input int idx);
        logic [79:0] expCsr;
        logic [31:0] expPc;
        expPc  = 32'h1C00_0000 + idx * 4;
        expCsr = {14'h0180, 1'b1, 1'b1, 32'hFFFF_0000, 32'hA5A5_0000 + idx};
        @(negedge clk);
        driveIdle();
        from_valid = 1'b1; from_pc = expPc; alu_result_EX = v.addr; rf_we_EX = v.rfWe;
        rf_waddr_EX = 5'd3; res_from_mem_EX = v.resMem; load_op_EX = v.loadOp;
        mem_req_EX = v.memReq; rd_cnt_EX = v.rdCnt; rd_timer_EX = v.timer;
        csr_bus_EX = expCsr; ertn_EX = v.ertn; exc_EX = v.exc;
        from_allowin = 1'b1; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        #1 checkOutput({v.name, " empty to_allowin"}, to_allowin, 1'b1);
        @(posedge clk);
        @(negedge clk);
        driveIdle();
        data_sram_data_ok = v.memReq;
        data_sram_rdata   = v.memReq ? v.rdata : 32'h0;
        #1;
        checkOutput({v.name, " to_valid"}, to_valid, 1'b1);
        checkOutput({v.name, " rf_we"}, rf_we, v.rfWe);
        checkOutput({v.name, " rf_wdata"}, rf_wdata, v.expWdata);
        checkOutput({v.name, " ex_MEM"}, ex_MEM, v.expExMem);
        checkOutput({v.name, " flush_MEM"}, flush_MEM, v.expFlush);
        checkOutput({v.name, " ertn_out"}, ertn_out, v.expFlush);
        checkOutput({v.name, " exc_out"}, exc_out, v.exc);
        checkOutput({v.name, " mem_wait"}, mem_wait, 1'b0);
        checkOutput({v.name, " PC"}, PC, expPc);
        checkOutput({v.name, " vaddr"}, vaddr, v.addr);
        checkOutput({v.name, " csr_bus"}, csr_bus, expCsr);
`ifdef PIPE_MEM_FWD_EN
        checkOutput({v.name, " fwd_valid"}, fwd_valid, v.rfWe);
        checkOutput({v.name, " fwd_data"}, fwd_data, v.expWdata);
`endif
        @(posedge clk);
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        checkOutput({v.name, " to_valid once"}, to_valid, 1'b0);
        checkOutput({v.name, " csr en/we gated"}, csr_bus[65:64], 2'b00);
    endtask

    task automatic bufferSequence();
        @(negedge clk);
        driveInstr(makeLoad(5'b00010, 32'h0000_2002));
        from_allowin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        driveIdle();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBEEF_0000;
        #1 checkOutput("buf arrival to_valid", to_valid, 1'b1);
        checkOutput("buf arrival to_allowin", to_allowin, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            data_sram_data_ok = 1'b0; data_sram_rdata = 32'h1234_5678;
            from_allowin = (i == 2);
            #1;
            checkOutput("buf held to_valid", to_valid, 1'b1);
            checkOutput("buf held mem_wait", mem_wait, 1'b0);
            checkOutput("buf held rf_wdata", rf_wdata, 32'h0000_BEEF);
        end
        @(posedge clk);
        @(negedge clk);
        #1 checkOutput("buf left to_valid", to_valid, 1'b0);
    endtask

    task automatic flushSequence();
        @(negedge clk);
        driveInstr(makeLoad(5'b00001, 32'h0000_3000));
        from_allowin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        driveIdle();
        #1 checkOutput("flush wait mem_wait", mem_wait, 1'b1);
        flush_WB = 1'b1;
        #1 checkOutput("flush to_valid", to_valid, 1'b0);
        checkOutput("flush to_allowin", to_allowin, 1'b1);
        @(posedge clk);
        @(negedge clk);
        flush_WB = 1'b0;
        driveInstr(makeLoad(5'b00001, 32'h0000_3004));
        #1 checkOutput("post-flush to_valid", to_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        driveIdle();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
        #1 checkOutput("stale resp to_valid", to_valid, 1'b0);
        checkOutput("stale resp mem_wait", mem_wait, 1'b1);
        @(posedge clk);
        @(negedge clk);
        data_sram_rdata = 32'h1111_2222;
        #1 checkOutput("fresh resp to_valid", to_valid, 1'b1);
        checkOutput("fresh resp rf_wdata", rf_wdata, 32'h1111_2222);
        @(posedge clk);
        @(negedge clk);
        data_sram_data_ok = 1'b0;
    endtask

    task automatic resetPulse();
        @(negedge clk);
        driveIdle();
        data_sram_data_ok = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic resetSequence();
        // Reset while a load waits on its response.
        @(negedge clk);
        driveInstr(makeLoad(5'b00001, 32'h0000_4000));
        from_allowin = 1'b1;
        @(posedge clk);
        resetPulse();
        #1 checkOutput("rst to_valid", to_valid, 1'b0);
        checkOutput("rst to_allowin", to_allowin, 1'b1);
        checkOutput("rst mem_wait", mem_wait, 1'b0);
        checkOutput("rst rf_we", rf_we, 1'b0);
        // Reset with a buffered response: the next load must wait for its own.
        driveInstr(makeLoad(5'b00001, 32'h0000_4004));
        from_allowin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        driveIdle();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h7777_7777;
        @(posedge clk);
        resetPulse();
        driveInstr(makeLoad(5'b00001, 32'h0000_4008));
        from_allowin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        driveIdle();
        #1 checkOutput("rst buf cleared mem_wait", mem_wait, 1'b1);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h55AA_33CC;
        #1 checkOutput("rst buf load rf_wdata", rf_wdata, 32'h55AA_33CC);
        @(posedge clk);
        // Reset with a pending discard: the next response must be accepted.
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        driveInstr(makeLoad(5'b00001, 32'h0000_400C));
        @(posedge clk);
        @(negedge clk);
        driveIdle();
        ex_WB = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ex_WB = 1'b0;
        resetPulse();
        driveInstr(makeLoad(5'b00001, 32'h0000_4010));
        @(posedge clk);
        @(negedge clk);
        driveIdle();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_F00D;
        #1 checkOutput("rst cnt cleared to_valid", to_valid, 1'b1);
        checkOutput("rst cnt cleared rf_wdata", rf_wdata, 32'h0BAD_F00D);
        @(posedge clk);
        @(negedge clk);
        data_sram_data_ok = 1'b0;
    endtask

    // Random traffic: memory answers 1..4 cycles after entry regardless of write-back readiness.
    task automatic runRandom(input int cycles);
        instr_t exInstr, stageInstr;
        bit exPending = 0, stageValid = 0, stageSeen = 0, respPending = 0;
        bit ready, leave, enter, expAllow;
        int respDelay = 0, stall = 0;
        logic [31:0] junk;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (!exPending && $urandom_range(0, 3) != 0) begin
                exInstr   = randInstr();
                exPending = 1;
            end
            if (exPending) driveInstr(exInstr);
            else driveIdle();
            from_allowin = ($urandom_range(0, 3) != 0);
            if (respPending && respDelay == 0) begin
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = stageInstr.data;
            end else begin
                junk = $urandom;
                data_sram_data_ok = 1'b0;
                data_sram_rdata   = junk;
            end
            #1;
            if (data_sram_data_ok) stageSeen = 1;
            ready    = stageValid && (!stageInstr.memReq || stageSeen);
            expAllow = !stageValid || (ready && from_allowin);
            checkOutput("rnd to_valid", to_valid, ready);
            checkOutput("rnd to_allowin", to_allowin, expAllow);
            if (stageValid && stageInstr.resMem) checkOutput("rnd mem_wait", mem_wait, !ready);
            leave = ready && from_allowin;
            if (leave) begin
                checkOutput("rnd rf_we", rf_we, stageInstr.rfWe);
                checkOutput("rnd rf_waddr", rf_waddr, stageInstr.waddr);
                checkOutput("rnd rf_wdata", rf_wdata, refResult(stageInstr));
            end
            if (data_sram_data_ok) respPending = 0;
            else if (respPending) respDelay--;
            enter = exPending && expAllow;
            if (leave) stageValid = 0;
            if (enter) begin
                stageValid = 1; stageInstr = exInstr; stageSeen = 0; exPending = 0;
                if (exInstr.memReq) begin
                    respPending = 1;
                    respDelay   = $urandom_range(0, 3);
                end
            end
            stall = (stageValid && !leave && !enter) ? stall + 1 : 0;
            if (stall > 50) begin
                checkCount++;
                failCount++;
                $display("[TB] FAIL rnd progress: stalled %0d cycles, required at most 50", stall);
                break;
            end
            @(posedge clk);
        end
        @(negedge clk);
        driveIdle();
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = makeVec("ld_b",  5'b10000, 1, 1, 1, 0, 0, 6'd0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 32'hFFFF_FF80, 0, 0);
        vecs[1] = makeVec("ld_bu", 5'b01000, 1, 1, 1, 0, 0, 6'd0, 32'h0000_1002, 32'h0, 32'h80FF_1234, 32'h0000_00FF, 0, 0);
        vecs[2] = makeVec("ld_h",  5'b00100, 1, 1, 1, 0, 0, 6'd0, 32'h0000_1002, 32'h0, 32'h80FF_1234, 32'hFFFF_80FF, 0, 0);
        vecs[3] = makeVec("ld_hu", 5'b00010, 1, 1, 1, 0, 0, 6'd0, 32'h0000_1000, 32'h0, 32'h80FF_9234, 32'h0000_9234, 0, 0);
        vecs[4] = makeVec("ld_w",  5'b00001, 1, 1, 1, 0, 0, 6'd0, 32'h0000_1004, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 0);
        vecs[5] = makeVec("rd_cnt", 5'b00000, 1, 0, 0, 1, 0, 6'd0, 32'h0000_0055, 32'h0000_0ABC, 32'h0, 32'h0000_0ABC, 0, 0);
        vecs[6] = makeVec("ale",   5'b00000, 0, 0, 0, 0, 0, 6'b000100, 32'h0000_1001, 32'h0, 32'h0, 32'h0000_1001, 1, 0);
        vecs[7] = makeVec("ertn",  5'b00000, 0, 0, 0, 0, 1, 6'd0, 32'h0000_0040, 32'h0, 32'h0, 32'h0000_0040, 0, 1);

        reset = 1'b1;
        driveIdle();
        from_allowin = 1'b0; ex_WB = 1'b0; flush_WB = 1'b0;
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset to_valid", to_valid, 1'b0);
        checkOutput("reset to_allowin", to_allowin, 1'b1);
        checkOutput("reset rf_we", rf_we, 1'b0);
        checkOutput("reset rf_wdata", rf_wdata, 32'h0);
        checkOutput("reset mem_wait", mem_wait, 1'b0);
        checkOutput("reset csr_bus", csr_bus, 80'h0);
        checkOutput("reset ex_MEM", ex_MEM, 1'b0);
        checkOutput("reset PC", PC, 32'h0);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);
        bufferSequence();
        flushSequence();
        resetSequence();
        runRandom(800);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
